// File: rtl/traffic_light_fsm_if.sv
// traffic_light_fsm_if: inputs and registered outputs of the
// intersection sequencer, grouped for port connection.
interface traffic_light_fsm_if;
  logic       tick;
  logic       ped_req;
  logic       flash_en;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_pending;
  logic [2:0] state;
  logic [7:0] remaining;

  modport master (
    output tick, ped_req, flash_en,
    input  ns_light, ew_light, walk,
    input  ped_pending, state, remaining
  );

  modport slave (
    input  tick, ped_req, flash_en,
    output ns_light, ew_light, walk,
    output ped_pending, state, remaining
  );
endinterface

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: tick-driven two-way intersection sequencer
// with latched pedestrian walk and flashing-red override.
module traffic_light_fsm #(
  parameter int GREEN_TICKS   = 50,
  parameter int YELLOW_TICKS  = 20,
  parameter int ALL_RED_TICKS = 10,
  parameter int WALK_TICKS    = 40,
  parameter int FLASH_TICKS   = 5
) (
  input  logic                clk,
  input  logic                reset,
  traffic_light_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } state_t;

  localparam logic [7:0] G_LD = 8'(GREEN_TICKS - 1);
  localparam logic [7:0] Y_LD = 8'(YELLOW_TICKS - 1);
  localparam logic [7:0] R_LD = 8'(ALL_RED_TICKS - 1);
  localparam logic [7:0] W_LD = 8'(WALK_TICKS - 1);
  localparam logic [7:0] F_LD = 8'(FLASH_TICKS - 1);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       pend_q, pend_d;
  // next_dir: 1 = EW green follows the walk, 0 = NS green
  logic       dir_q, dir_d;
  logic       lit_q, lit_d;
  logic [2:0] ns_q, ns_d;
  logic [2:0] ew_q, ew_d;
  logic       walk_q, walk_d;

  function automatic logic [7:0] load(state_t s);
    logic [7:0] v;
    v = G_LD;
    case (s)
      NS_GREEN,
      EW_GREEN:  v = G_LD;
      NS_YELLOW,
      EW_YELLOW: v = Y_LD;
      ALL_RED_A,
      ALL_RED_B: v = R_LD;
      PED_WALK:  v = W_LD;
      FLASH:     v = F_LD;
      default:   v = G_LD;
    endcase
    return v;
  endfunction

  // State, timer, request latch and registered light outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NS_GREEN;
      timer_q <= G_LD;
      pend_q  <= 1'b0;
      dir_q   <= 1'b1;
      lit_q   <= 1'b1;
      ns_q    <= 3'b001;
      ew_q    <= 3'b100;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      lit_q   <= lit_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      walk_q  <= walk_d;
    end
  end

  // Next state, timer and the Moore decode of the next state
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    dir_d   = dir_q;
    lit_d   = lit_q;
    ns_d    = 3'b100;
    ew_d    = 3'b100;
    walk_d  = 1'b0;

    if (bus.flash_en && state_q != FLASH) begin
      state_d = FLASH;
      timer_d = F_LD;
      lit_d   = 1'b1;
    end else if (!bus.flash_en && state_q == FLASH) begin
      state_d = ALL_RED_B;
      timer_d = R_LD;
    end else if (bus.tick) begin
      if (timer_q != 8'd0) begin
        timer_d = timer_q - 8'd1;
      end else begin
        unique case (state_q)
          NS_GREEN:  state_d = NS_YELLOW;
          NS_YELLOW: state_d = ALL_RED_A;
          ALL_RED_A: state_d = pend_q ? PED_WALK : EW_GREEN;
          EW_GREEN:  state_d = EW_YELLOW;
          EW_YELLOW: state_d = ALL_RED_B;
          ALL_RED_B: state_d = pend_q ? PED_WALK : NS_GREEN;
          PED_WALK:  state_d = dir_q ? EW_GREEN : NS_GREEN;
          FLASH:     lit_d   = ~lit_q;
          default:   state_d = NS_GREEN;
        endcase
        timer_d = load(state_d);
      end
    end

    if (state_d == PED_WALK && state_q != PED_WALK) begin
      dir_d  = (state_q == ALL_RED_A);
      pend_d = 1'b0;
    end else if (bus.ped_req && state_q != PED_WALK) begin
      pend_d = 1'b1;
    end

    unique case (state_d)
      NS_GREEN:  ns_d = 3'b001;
      NS_YELLOW: ns_d = 3'b010;
      EW_GREEN:  ew_d = 3'b001;
      EW_YELLOW: ew_d = 3'b010;
      PED_WALK:  walk_d = 1'b1;
      FLASH: begin
        ns_d = {lit_d, 2'b00};
        ew_d = {lit_d, 2'b00};
      end
      default: ;
    endcase
  end

  assign bus.state       = state_q;
  assign bus.remaining   = timer_q;
  assign bus.ped_pending = pend_q;
  assign bus.ns_light    = ns_q;
  assign bus.ew_light    = ew_q;
  assign bus.walk        = walk_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb_traffic_light_fsm: scoreboard bench, reference model predicts
// every cycle's outputs and directed checks pin the key timings.
module tb_traffic_light_fsm;

  localparam int GT = 50;
  localparam int YT = 20;
  localparam int RT = 10;
  localparam int WT = 40;
  localparam int FT = 5;

  logic clk = 1'b0;
  logic reset;
  traffic_light_fsm_if bus();

  traffic_light_fsm #(
    .GREEN_TICKS(GT), .YELLOW_TICKS(YT),
    .ALL_RED_TICKS(RT), .WALK_TICKS(WT),
    .FLASH_TICKS(FT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n = 0;
  logic [18:0] sb[$];

  int m_state, m_timer;
  bit m_pend, m_dir, m_lit;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at n=%0d: got %h want %h", tag, n, got, exp);
    end
  endtask

  function automatic int dur(int s);
    case (s)
      0, 3: return GT;
      1, 4: return YT;
      2, 5: return RT;
      6: return WT;
      default: return FT;
    endcase
  endfunction

  task automatic model_step(input bit rst, tk, pr, fe);
    int nx;
    if (rst) begin
      m_state = 0; m_timer = GT - 1;
      m_pend = 0; m_dir = 1; m_lit = 1;
      return;
    end
    nx = m_state;
    if (fe && m_state != 7) begin
      nx = 7; m_timer = FT - 1; m_lit = 1;
    end else if (!fe && m_state == 7) begin
      nx = 5; m_timer = RT - 1;
    end else if (tk) begin
      if (m_timer > 0) m_timer--;
      else begin
        case (m_state)
          0: nx = 1;
          1: nx = 2;
          2: nx = m_pend ? 6 : 3;
          3: nx = 4;
          4: nx = 5;
          5: nx = m_pend ? 6 : 0;
          6: nx = m_dir ? 3 : 0;
          default: m_lit = !m_lit;
        endcase
        m_timer = dur(nx) - 1;
      end
    end
    if (nx == 6 && m_state != 6) begin
      m_dir = (m_state == 2);
      m_pend = 0;
    end else if (pr && m_state != 6) m_pend = 1;
    m_state = nx;
  endtask

  function automatic logic [18:0] expect_vec();
    logic [2:0] ns, ew;
    logic w;
    ns = 3'b100; ew = 3'b100; w = 1'b0;
    case (m_state)
      0: ns = 3'b001;
      1: ns = 3'b010;
      3: ew = 3'b001;
      4: ew = 3'b010;
      6: w = 1'b1;
      7: begin ns = {m_lit, 2'b00}; ew = {m_lit, 2'b00}; end
      default: ;
    endcase
    return {3'(m_state), 8'(m_timer), ns, ew, w, m_pend};
  endfunction

  task automatic cyc(input bit rst, tk, pr, fe);
    logic [18:0] exp, got;
    @(negedge clk);
    reset = rst; bus.tick = tk;
    bus.ped_req = pr; bus.flash_en = fe;
    model_step(rst, tk, pr, fe);
    sb.push_back(expect_vec());
    @(posedge clk);
    #1;
    n++;
    exp = sb.pop_front();
    got = {bus.state, bus.remaining, bus.ns_light,
           bus.ew_light, bus.walk, bus.ped_pending};
    check("cycle", 32'(got), 32'(exp));
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    n = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ec[6] = '{50, 70, 80, 130, 150, 160};
    int es[6] = '{1, 2, 3, 4, 5, 0};
    int k, prev, t1, t2, t3, t4;
    reset = 1'b1; bus.tick = 0;
    bus.ped_req = 0; bus.flash_en = 0;

    // reset state and default sequence
    do_reset();
    check("rst_state", bus.state, 0);
    check("rst_rem", bus.remaining, 49);
    check("rst_ns", bus.ns_light, 3'b001);
    check("rst_ew", bus.ew_light, 3'b100);
    check("rst_walk", bus.walk, 0);
    check("rst_pend", bus.ped_pending, 0);
    k = 0; prev = 0;
    for (int i = 1; i <= 165; i++) begin
      cyc(0, 1, 0, 0);
      if (int'(bus.state) != prev) begin
        if (k < 6) begin
          check("seq_cyc", n, ec[k]);
          check("seq_st", bus.state, es[k]);
        end
        k++;
        prev = int'(bus.state);
      end
    end
    check("seq_cnt", k, 6);

    // pedestrian: request, mid-walk request, entry-edge request
    do_reset();
    for (int i = 1; i <= 205; i++) begin
      cyc(0, 1, i == 10 || i == 100 || i == 130 || i == 200, 0);
      if (i == 10) check("ped_set", bus.ped_pending, 1);
      if (i == 80) check("walk_on", bus.walk, 1);
      if (i == 80) check("walk_ns", bus.ns_light, 3'b100);
      if (i == 100) check("walk_req", bus.ped_pending, 0);
      if (i == 120) check("walk_to", bus.state, 3);
      if (i == 200) check("entry_st", bus.state, 6);
      if (i == 200) check("entry_pend", bus.ped_pending, 0);
    end

    // flash override mid EW_GREEN and exit via ALL_RED_B
    do_reset();
    for (int i = 1; i <= 145; i++) begin
      cyc(0, 1, 0, i >= 100 && i < 130);
      if (i == 100) check("fl_enter", bus.state, 7);
      if (i == 105) check("fl_dark", bus.ns_light, 3'b000);
      if (i == 110) check("fl_lit", bus.ew_light, 3'b100);
      if (i == 130) check("fl_exit", bus.state, 5);
      if (i == 140) check("fl_ns", bus.state, 0);
    end

    // sparse ticks every 7 cycles
    do_reset();
    t1 = 0; t2 = 0; t3 = 0; t4 = 0;
    for (int i = 1; i <= 1130; i++) begin
      prev = int'(bus.state);
      cyc(0, (i % 7) == 0, 0, 0);
      if (prev != int'(bus.state)) begin
        if (bus.state == 1) t1 = n;
        if (bus.state == 2) t2 = n;
        if (bus.state == 3) t3 = n;
        if (bus.state == 4) t4 = n;
      end
    end
    check("sp_green", t1, 350);
    check("sp_yellow", t2 - t1, 140);
    check("sp_ewg", t4 - t3, 350);

    // reset during walk with flash_en high
    do_reset();
    for (int i = 1; i <= 100; i++) cyc(0, 1, i == 5, 0);
    check("mid_walk", bus.state, 6);
    cyc(1, 1, 0, 1);
    check("mr_state", bus.state, 0);
    check("mr_rem", bus.remaining, 49);
    check("mr_walk", bus.walk, 0);
    check("mr_pend", bus.ped_pending, 0);
    cyc(0, 1, 0, 1);
    check("mr_flash", bus.state, 7);
    cyc(0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
